// File: rtl/gfx_cmd_issuer.sv
// Command issuer for the graphics-unit command bus.
// The CPU writes {wait, data} entries into a FIFO. The FSM replays them as
// single-cycle strobes with at least GAP idle cycles between strobes. Issue can
// optionally be confined to a window after each frame interrupt. A flagged
// entry can hold off further issue until the completion interrupt returns or a
// timeout expires.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a queued entry while the issue window is open
// ST_ISSUE | strobe cycle: out_start high, out_data valid
// ST_GAP   | enforcing idle spacing before the next strobe
// ST_WAIT  | flagged entry issued; waiting for done_irq or timeout
module gfx_cmd_issuer #(
    parameter int DEPTH   = 16,
    parameter int GAP     = 4,
    parameter int WINDOW  = 2048,
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cpu_w_i,
    input  logic [23:0]            cpu_data_i,
    input  logic                   cpu_wait_i,
    input  logic                   sync_en_i,
    input  logic                   frame_irq_i,
    input  logic                   done_irq_i,
    input  logic                   err_clr_i,
    output logic                   cpu_full_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [23:0]            out_data_o,
    output logic                   out_start_o,
    output logic                   busy_o,
    output logic                   overflow_o,
    output logic                   timeout_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [15:0]   WIN_LOAD   = 16'(WINDOW);
    localparam logic [7:0]    GAP_LOAD   = 8'(GAP);
    localparam logic [15:0]   TMO_LOAD   = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    logic [24:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          full_q;
    logic          overflow_q;
    logic [15:0]   win_cnt_q;
    state_t        state_q;
    logic [7:0]    gap_cnt_q;
    logic [15:0]   wait_cnt_q;
    logic          wait_flag_q;
    logic [23:0]   out_data_q;
    logic          out_start_q;
    logic          timeout_q;

    logic          push;
    logic          pop;
    logic          win_open;
    logic          fifo_empty;
    logic [24:0]   head;
    state_t        gap_next;

    assign fifo_empty = (level_q == '0);
    assign win_open   = !sync_en_i || (win_cnt_q != '0);
    assign push       = cpu_w_i && !full_q;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty && win_open;
    assign head       = mem_q[rd_ptr_q];

    // With GAP of one, the ST_IDLE decision cycle alone provides the spacing.
    assign gap_next = (GAP == 1) ? ST_IDLE : ST_GAP;

    // Entry storage; pointers gate every read, so the array needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cpu_wait_i, cpu_data_i};
        end
    end

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers, occupancy, registered full flag, and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            full_q  <= (level_d == LEVEL_FULL);
            if (err_clr_i) begin
                overflow_q <= 1'b0;
            end
            if (cpu_w_i && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Issue window: a frame pulse reloads the counter, otherwise it drains to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_cnt_q <= '0;
        end else if (frame_irq_i) begin
            win_cnt_q <= WIN_LOAD;
        end else if (win_cnt_q != '0) begin
            win_cnt_q <= win_cnt_q - 1'b1;
        end
    end

    // Issue sequencer with registered strobe, data, and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            wait_flag_q <= 1'b0;
            out_data_q  <= '0;
            out_start_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            out_start_q <= 1'b0;
            if (err_clr_i) begin
                timeout_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        out_data_q  <= head[23:0];
                        out_start_q <= 1'b1;
                        wait_flag_q <= head[24];
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // done_irq is deliberately ignored here, in the strobe cycle.
                    if (wait_flag_q) begin
                        wait_cnt_q <= TMO_LOAD;
                        state_q    <= ST_WAIT;
                    end else begin
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= gap_next;
                    end
                end
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q - 1'b1;
                    if (gap_cnt_q <= 8'd2) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (done_irq_i) begin
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= gap_next;
                    end else if (wait_cnt_q == 16'd1) begin
                        timeout_q <= 1'b1;
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= gap_next;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_full_o    = full_q;
    assign level_o       = level_q;
    assign out_data_o    = out_data_q;
    assign out_start_o   = out_start_q;
    assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow_o    = overflow_q;
    assign timeout_err_o = timeout_q;

endmodule

// File: doc/gfx_cmd_issuer.md
Name: gfx_cmd_issuer

Overview:
- Initiator side of the 24-bit command bus (data word plus single-cycle `start` strobe) consumed by the graphics unit's clearer, text-buffer, background, delta/palette and sprite controllers.
- Buffers CPU-written command words in a FIFO.
- Replays them onto the bus with a guaranteed minimum spacing.
- Optionally confines issue to a window after the frame interrupt.
- Optionally stalls after a flagged command until the completion interrupt returns.

Parameters:
- DEPTH, 16: FIFO entries; power of two, 2..64.
- GAP, 4: minimum low cycles of `out_start` between two strobes; 1..255.
- WINDOW, 2048: cycles the issue window stays open after a `frame_irq` pulse; 1..65535.
- TIMEOUT, 65535: maximum cycles spent waiting for `done_irq`; 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_w  in  1  push strobe, one entry per high cycle.
- cpu_data  in  24  command word to push.
- cpu_wait  in  1  pushed with the entry; 1 = wait for `done_irq` after issuing it.
- sync_en  in  1  1 = issue only inside the frame window; 0 = window always open.
- frame_irq  in  1  single-cycle frame-start pulse.
- done_irq  in  1  single-cycle completion pulse (clear/text done).
- err_clr  in  1  clears the sticky error flags.
- cpu_full  out  1  FIFO full (registered).
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- out_data  out  24  command word to the graphics unit.
- out_start  out  1  one-cycle strobe; `out_data` is valid in the same cycle.
- busy  out  1  high when not IDLE or FIFO non-empty.
- overflow  out  1  sticky: a push was attempted while full.
- timeout_err  out  1  sticky: the `done_irq` wait expired.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, pointers 0, `level`=0, `cpu_full`=0, `out_data`=0, `out_start`=0, `busy`=0, `overflow`=0, `timeout_err`=0, window closed, state IDLE, all counters 0.
- FIFO entry is 25 bits: {`cpu_wait`, `cpu_data`}.
  - Push when `cpu_w` && !`cpu_full`. A push while full is dropped and sets `overflow`.
  - Simultaneous push and pop is legal; occupancy is unchanged.
  - No bypass: a word pushed into an empty FIFO is poppable from the next edge.
  - Pointers wrap modulo DEPTH.
- Window:
  - `frame_irq`=1 loads the window counter with WINDOW; otherwise it decrements to 0.
  - win_open = !`sync_en` || counter!=0.
  - A `frame_irq` while the window is already open reloads the counter; windows do not accumulate.
- States:
  - IDLE: if FIFO non-empty && win_open, pop at this edge, register `out_data`, set `out_start`=1, latch the wait flag, go to ISSUE.
  - ISSUE (1 cycle, `out_start` high): if the wait flag is set, go to WAIT, else go to GAP with the gap counter = GAP.
  - GAP: decrement; when the counter reaches 1 go to IDLE. This gives GAP low cycles minimum between strobes.
  - WAIT: `done_irq` is sampled from the cycle after the strobe onward.
    - `done_irq`=1: go to GAP (load GAP).
    - Counter reaches TIMEOUT: set `timeout_err`, go to GAP.
    - A `done_irq` coincident with the strobe cycle is ignored.
- Window closing while in ISSUE, GAP or WAIT does not abort the command in flight. Only the IDLE issue decision tests win_open.
- `out_data` holds its last value between strobes. `out_start` is high for exactly one cycle per popped entry.
- Latency: push at edge N into an empty FIFO with the window open and state IDLE gives `out_start`=1 in the cycle after edge N+1.
- `err_clr` clears both sticky flags. If a set condition coincides with `err_clr`, set wins.
- `level` and `cpu_full` update at the same edge as push/pop. `cpu_full` = (`level`==DEPTH).
- `rst` asserted mid-operation: any pending strobe is aborted immediately and the FIFO contents are discarded.

Test Plan:
- Burst push of 3 words 0x000001, 0x000002, 0x000003 (`sync_en`=0, `cpu_wait`=0, GAP=4) -> 3 strobes in order, exactly 4 low cycles between consecutive strobes; `busy` falls after the final GAP.
- Push 17 words with DEPTH=16 and no pops possible (`sync_en`=1, no `frame_irq`) -> `cpu_full`=1 after 16, `level`=16, `overflow`=1, 17th word never appears on `out_data`; `err_clr` -> `overflow`=0.
- `sync_en`=1, WINDOW=10, 5 words queued, `frame_irq` pulse, GAP=4 -> strobes start 2 cycles after the pulse; no strobe is initiated from IDLE once the window has expired; remaining words are issued after the next `frame_irq`.
- Word 0xA00000 pushed with `cpu_wait`=1, then 0x000055 -> second strobe only GAP+1 cycles after `done_irq` (pulsed 20 cycles after the first strobe); a `done_irq` on the strobe cycle itself is ignored.
- TIMEOUT=8, `cpu_wait`=1 entry, no `done_irq` -> `timeout_err`=1 eight cycles after WAIT entry; the next queued word is issued after GAP.
- `rst` driven low during WAIT with 4 entries queued -> all outputs 0 asynchronously; after release, no strobes occur and `level`=0.
